sub18_pipe: RTL and testbench
=============================

// Module: sub18_pipe
// PURPOSE
//  Two-stage pipelined 18-bit subtractor producing z = a - b as a 19-bit two's-complement result.
//  Operands are unsigned. z[18] is the sign/borrow bit, so every difference from -(2^18-1) to +(2^18-1) is exact.
//  The low and high halves are split across stages to meet timing. The block sits in the datapath as a
//  free-running arithmetic unit with no handshake.
// PARAMETERS
//  WIDTH  18  operand width; z is WIDTH+1 bits
//  LSB_W  9   width of the low slice computed in stage 1 (1 <= LSB_W < WIDTH)
// PORTS
//  clk  in   1   single clock; all state updates on its rising edge
//  rst  in   1   reset, synchronous and active-high
//  a    in   18  minuend, unsigned
//  b    in   18  subtrahend, unsigned
//  z    out  19  registered difference {1'b0,a} - {1'b0,b}, two's complement
// BEHAVIOUR
//  - Reset is synchronous and active-high: while rst=1 at a rising clk edge, every pipeline register clears to 0.
//    z=0 on the cycle after that edge. Operands in flight are discarded; no stale result appears after rst falls.
//  - Stage 1 (edge N): register a and b. Compute the low slice d_lo = a[LSB_W-1:0] - b[LSB_W-1:0].
//    Register d_lo and its borrow-out br.
//  - Stage 2 (edge N+1): compute d_hi = {1'b0,a_hi} - {1'b0,b_hi} - br over WIDTH-LSB_W+1 bits.
//    Register z = {d_hi, d_lo}.
//  - Latency: exactly 2 clk edges from sampling a/b to z updating. Throughput: one result per cycle.
//  - z holds its value while inputs are stable. There is no combinational path from a/b to z.
//  - Width rule: operands are zero-extended to 19 bits and the result wraps modulo 2^19, which never overflows.
//  - Boundaries:
//    a=b gives z=0.
//    a=2^18-1, b=0 gives z=0x3FFFF.
//    a=0, b=2^18-1 gives z=0x40001, which is -262143.
//    A borrow across the slice boundary must propagate correctly, for example a=0x00200, b=0x00001.
//  - If rst and new operands coincide, reset wins. Operands are sampled normally on the first edge with rst=0.
// CONFIGURATION
//  - SUB18_SATURATE_EN defined: stage 2 clamps negative results, so z=0 whenever a<b.
//    The clamp stays inside stage 2, so latency is unchanged.
//  - SUB18_SATURATE_EN undefined: full signed 19-bit result as specified above.
// STRUCTURE
//  - Package sub18_pkg holds:
//    the WIDTH and LSB_W defaults,
//    the derived constants HI_W = WIDTH-LSB_W and Z_W = WIDTH+1,
//    LATENCY = 2,
//    a typedef for the stage-1 register bundle: a_hi, b_hi, d_lo, br.
//  - Sub-module sub_slice: parameterised ripple subtractor with ports x, y, bin, d and bout.
//    It is built from per-bit full subtractors.
//  - sub18_pipe instantiates sub_slice twice: low slice with bin=0, high slice with bin=br.
// TESTING
//  - Reset: hold rst=1 for 2 edges with a=0x3FFFF, b=0 -> z=0 throughout. After rst falls, z=0x3FFFF 2 edges later.
//  - a=0x3FFFF, b=0x1FFFF -> z=19'h20000 (binary 0100000000000000000) after 2 edges and held while inputs are stable.
//  - a=0, b=0x3FFFF -> z=19'h40001. With SUB18_SATURATE_EN defined, z=0.
//  - Cross-slice borrow: a=0x00200, b=0x00001 -> z=0x001FF.
//    Then a=0x20000, b=0x1FFFF -> z=0x00001.
//  - Back-to-back pipeline: present a new random pair on each of 1000 cycles. The z sequence must match
//    {0,a}-{0,b} delayed by 2 cycles.
//  - Mid-stream reset: pulse rst for 1 cycle during a stream -> z=0 on the next cycle. No pre-reset result
//    appears afterward.

Source files
------------

// File: rtl/sub18_pkg.sv
// rtl/sub18_pkg.sv - shared widths, latency and stage-1 bundle type for sub18_pipe
package sub18_pkg;

    localparam int WIDTH   = 18;
    localparam int LSB_W   = 9;
    localparam int HI_W    = WIDTH - LSB_W;
    localparam int Z_W     = WIDTH + 1;
    localparam int LATENCY = 2;

    typedef struct packed {
        logic [HI_W-1:0]  a_hi;
        logic [HI_W-1:0]  b_hi;
        logic [LSB_W-1:0] d_lo;
        logic             br;
    } stage1_t;

endpackage

// File: rtl/sub18_pipe_sub_slice.sv
// rtl/sub18_pipe_sub_slice.sv - ripple subtractor d = x - y - bin built from per-bit full subtractors
module sub_slice #(
    parameter int W = 9
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] borrow;

    assign borrow[0] = bin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign d[i]          = x[i] ^ y[i] ^ borrow[i];
        assign borrow[i + 1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow[i]);
    end

    assign bout = borrow[W];

endmodule

// File: rtl/sub18_pipe.sv
// rtl/sub18_pipe.sv - two-stage 18-bit subtractor z = a - b, 19-bit two's complement result
// Optional SUB18_SATURATE_EN: clamp negative results to zero inside stage 2.
module sub18_pipe
    import sub18_pkg::*;
#(
    parameter int WIDTH = sub18_pkg::WIDTH,
    parameter int LSB_W = sub18_pkg::LSB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   z
);

    localparam int HW = WIDTH - LSB_W;

    typedef struct packed {
        logic [HW-1:0]    a_hi;
        logic [HW-1:0]    b_hi;
        logic [LSB_W-1:0] d_lo;
        logic             br;
    } s1_t;

    s1_t            s1_q;
    s1_t            s1_d;
    logic [WIDTH:0] z_q;
    logic [WIDTH:0] z_d;

    logic [LSB_W-1:0] lo_diff;
    logic             lo_borrow;
    logic [HW-1:0]    hi_diff;
    logic             hi_borrow;

    sub_slice #(.W(LSB_W)) u_lo (
        .x    (a[LSB_W-1:0]),
        .y    (b[LSB_W-1:0]),
        .bin  (1'b0),
        .d    (lo_diff),
        .bout (lo_borrow)
    );

    // Borrow-out of the zero-extended high subtract is exactly the sign bit of z.
    sub_slice #(.W(HW)) u_hi (
        .x    (s1_q.a_hi),
        .y    (s1_q.b_hi),
        .bin  (s1_q.br),
        .d    (hi_diff),
        .bout (hi_borrow)
    );

    always_comb begin
        s1_d      = '0;
        s1_d.a_hi = a[WIDTH-1:LSB_W];
        s1_d.b_hi = b[WIDTH-1:LSB_W];
        s1_d.d_lo = lo_diff;
        s1_d.br   = lo_borrow;
    end

    always_comb begin
        z_d = {hi_borrow, hi_diff, s1_q.d_lo};
`ifdef SUB18_SATURATE_EN
        if (hi_borrow) begin
            z_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            z_q  <= '0;
        end else begin
            s1_q <= s1_d;
            z_q  <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: tb/tb_sub18_pipe.sv
// tb/tb_sub18_pipe.sv - directed and streaming self-checking bench for sub18_pipe
module tb_sub18_pipe;

    logic        clk;
    logic        rst;
    logic [17:0] a;
    logic [17:0] b;
    logic [18:0] z;

    int checks;
    int errors;

    sub18_pipe dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .z   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] ref_sub(input logic [17:0] x, input logic [17:0] y);
        logic [18:0] r;
        r = {1'b0, x} - {1'b0, y};
`ifdef SUB18_SATURATE_EN
        if (x < y) r = '0;
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a   = 18'h3FFFF;
        b   = 18'h00000;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (z !== 19'h00000) begin
                errors++;
                $display("FAIL reset_hold[%0d] z=%h expected=%h", i, z, 19'h00000);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (z !== 19'h00000) begin
            errors++;
            $display("FAIL reset_release_edge1 z=%h expected=%h", z, 19'h00000);
        end
        step();
        checks++;
        if (z !== 19'h3FFFF) begin
            errors++;
            $display("FAIL reset_release_edge2 z=%h expected=%h", z, 19'h3FFFF);
        end
    endtask

    task automatic test_hold();
        a = 18'h3FFFF;
        b = 18'h1FFFF;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (z !== 19'h20000) begin
                errors++;
                $display("FAIL hold[%0d] z=%h expected=%h", i, z, 19'h20000);
            end
            step();
        end
    endtask

    task automatic test_negative();
        logic [18:0] exp_neg;
`ifdef SUB18_SATURATE_EN
        exp_neg = 19'h00000;
`else
        exp_neg = 19'h40001;
`endif
        a = 18'h00000;
        b = 18'h3FFFF;
        step();
        step();
        checks++;
        if (z !== exp_neg) begin
            errors++;
            $display("FAIL negative_max z=%h expected=%h", z, exp_neg);
        end
        a = 18'h15A5A;
        b = 18'h15A5A;
        step();
        step();
        checks++;
        if (z !== 19'h00000) begin
            errors++;
            $display("FAIL equal_operands z=%h expected=%h", z, 19'h00000);
        end
    endtask

    task automatic test_cross_borrow();
        a = 18'h00200;
        b = 18'h00001;
        step();
        step();
        checks++;
        if (z !== 19'h001FF) begin
            errors++;
            $display("FAIL cross_borrow_a z=%h expected=%h", z, 19'h001FF);
        end
        a = 18'h20000;
        b = 18'h1FFFF;
        step();
        step();
        checks++;
        if (z !== 19'h00001) begin
            errors++;
            $display("FAIL cross_borrow_b z=%h expected=%h", z, 19'h00001);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] ah [0:1001];
        logic [17:0] bh [0:1001];
        for (int i = 0; i < 1002; i++) begin
            if (i >= 2) begin
                checks++;
                if (z !== ref_sub(ah[i-2], bh[i-2])) begin
                    errors++;
                    $display("FAIL stream[%0d] a=%h b=%h z=%h expected=%h",
                             i - 2, ah[i-2], bh[i-2], z, ref_sub(ah[i-2], bh[i-2]));
                end
            end
            if (i < 1000) begin
                ah[i] = 18'($urandom);
                bh[i] = 18'($urandom);
            end else begin
                ah[i] = ah[i-1];
                bh[i] = bh[i-1];
            end
            a = ah[i];
            b = bh[i];
            step();
        end
    endtask

    task automatic test_midstream_reset();
        a = 18'h12345;
        b = 18'h01111;
        step();
        a = 18'h2ABCD;
        b = 18'h00FFF;
        step();
        rst = 1'b1;
        a   = 18'h3F000;
        b   = 18'h00F00;
        step();
        checks++;
        if (z !== 19'h00000) begin
            errors++;
            $display("FAIL midreset_pulse z=%h expected=%h", z, 19'h00000);
        end
        rst = 1'b0;
        a   = 18'h00400;
        b   = 18'h00001;
        step();
        checks++;
        if (z !== 19'h00000) begin
            errors++;
            $display("FAIL midreset_no_stale z=%h expected=%h", z, 19'h00000);
        end
        step();
        checks++;
        if (z !== 19'h003FF) begin
            errors++;
            $display("FAIL midreset_resume z=%h expected=%h", z, 19'h003FF);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        a      = '0;
        b      = '0;
        @(negedge clk);
        test_reset();
        test_hold();
        test_negative();
        test_cross_borrow();
        test_back_to_back();
        test_midstream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
